// File: rtl/serial_paralelo_rx_n.sv
// serial_paralelo_rx_n
//   Serial-to-parallel receiver with comma-based word alignment and
//   round-robin distribution of data words over N_CH output lanes.
//   The receiver hunts for COMMA at any bit offset. It then needs
//   LOCK_COUNT consecutive word-aligned commas before it locks. Once
//   locked it stays locked until reset. Each non-comma word goes to the
//   next lane. A comma while locked restarts distribution at lane 0.
//
// Ports
//   clk_32f   : in  1         bit clock, one serial bit per rising edge
//   reset     : in  1         asynchronous, active-high reset
//   data_in   : in  1         serial data, MSB of each word first
//   data_out  : out N_CH*W    lane k at [k*W +: W], holds last word written
//   valid_out : out N_CH      one-cycle strobe for the lane just written
//   active    : out 1         high while locked
module serial_paralelo_rx_n #(
    parameter int unsigned         W          = 8,
    parameter logic [W-1:0]        COMMA      = 8'hBC,
    parameter int unsigned         LOCK_COUNT = 4,
    parameter int unsigned         N_CH       = 4
) (
    input  logic                clk_32f,
    input  logic                reset,
    input  logic                data_in,
    output logic [N_CH*W-1:0]   data_out,
    output logic [N_CH-1:0]     valid_out,
    output logic                active
);

    localparam int unsigned BC_W = $clog2(W);
    localparam int unsigned CC_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [W-1:0]      sr;
    logic [W-1:0]      nw;
    logic [BC_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [CC_W-1:0]   comma_cnt, comma_cnt_nxt;
    logic [CH_W-1:0]   ch_ptr, ch_ptr_nxt;
    logic              boundary;
    logic              is_comma;
    logic              load;

    // nw is the word that includes the bit sampled on this edge. Decisions
    // use nw instead of sr, so a word's lane and strobe are updated on the
    // same edge that samples its last bit.
    assign nw       = {sr[W-2:0], data_in};
    assign is_comma = (nw == COMMA);
    assign boundary = (bit_cnt == BC_W'(W - 1));

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        comma_cnt_nxt = comma_cnt;
        ch_ptr_nxt    = ch_ptr;
        load          = 1'b0;

        if (state != HUNT) begin
            bit_cnt_nxt = boundary ? '0 : bit_cnt + 1'b1;
        end

        case (state)
            HUNT: begin
                if (is_comma) begin
                    bit_cnt_nxt   = '0;
                    comma_cnt_nxt = CC_W'(1);
                    ch_ptr_nxt    = '0;
                    state_nxt     = (LOCK_COUNT == 1) ? LOCKED : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_nxt = comma_cnt + 1'b1;
                        if (comma_cnt + 1'b1 == CC_W'(LOCK_COUNT)) begin
                            state_nxt  = LOCKED;
                            ch_ptr_nxt = '0;
                        end
                    end else begin
                        comma_cnt_nxt = '0;
                        state_nxt     = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (is_comma) begin
                        ch_ptr_nxt = '0;
                    end else begin
                        load       = 1'b1;
                        ch_ptr_nxt = (ch_ptr == CH_W'(N_CH - 1)) ? '0 : ch_ptr + 1'b1;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            sr        <= '0;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            ch_ptr    <= '0;
            data_out  <= '0;
            valid_out <= '0;
            active    <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= nw;
            bit_cnt   <= bit_cnt_nxt;
            comma_cnt <= comma_cnt_nxt;
            ch_ptr    <= ch_ptr_nxt;
            active    <= (state_nxt == LOCKED);
            valid_out <= '0;
            if (load) begin
                data_out[ch_ptr*W +: W] <= nw;
                valid_out[ch_ptr]       <= 1'b1;
            end
        end
    end

endmodule

// File: doc/serial_paralelo_rx_n.md
SERIAL_PARALELO_RX_N -- requirements
Module: serial_paralelo_rx_n

Interface
REQ-001 SHALL have parameter W, default 8, bits per word (W >= 2).
REQ-002 SHALL have parameter COMMA, default 8'hBC (W bits), alignment/idle character.
REQ-003 SHALL have parameter LOCK_COUNT, default 4, consecutive aligned commas needed for lock (>= 1).
REQ-004 SHALL have parameter N_CH, default 4, number of output lanes (power of two, >= 1).
REQ-005 SHALL have port clk_32f, input, 1, the single clock (one serial bit sampled per rising edge); all state on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port data_in, input, 1, serial data, MSB of each word first.
REQ-008 SHALL have port data_out, output, N_CH*W, lane k at bits [k*W +: W], registered.
REQ-009 SHALL have port valid_out, output, N_CH, one-cycle strobe per lane, registered.
REQ-010 SHALL have port active, output, 1, high while in LOCKED, registered.

Function
REQ-011 SHALL shift sr <= {sr[W-2:0], data_in} on every clock edge; "next word" nw denotes {sr[W-2:0], data_in}.
REQ-012 SHALL implement states HUNT, ALIGN, LOCKED, with bit counter bit_cnt (0..W-1) and comma counter comma_cnt.
REQ-013 HUNT: on any edge where nw == COMMA, SHALL set bit_cnt <= 0, comma_cnt <= 1 and go to ALIGN (directly to LOCKED if LOCK_COUNT == 1); otherwise remain, bit_cnt ignored.
REQ-014 Outside HUNT, SHALL increment bit_cnt each edge, wrapping W-1 -> 0; a word boundary is an edge with bit_cnt == W-1 and nw is the completed word.
REQ-015 ALIGN, at word boundary: nw == COMMA SHALL increment comma_cnt and go to LOCKED when the new count equals LOCK_COUNT; nw != COMMA SHALL return to HUNT with comma_cnt <= 0.
REQ-016 ALIGN and HUNT SHALL never assert valid_out nor modify data_out.
REQ-017 LOCKED, at word boundary with nw != COMMA: SHALL load lane ch_ptr of data_out with nw, assert valid_out[ch_ptr] for exactly that following cycle, and increment ch_ptr modulo N_CH.
REQ-018 LOCKED, at word boundary with nw == COMMA: SHALL assert no valid, leave data_out unchanged, and set ch_ptr <= 0.
REQ-019 Latency: lane data and strobe SHALL be updated on the same edge that samples the word's last bit (zero extra pipeline).
REQ-020 data_out lanes SHALL hold their last value until overwritten; at most one valid_out bit high per cycle.
REQ-021 ch_ptr SHALL be 0 on entry to LOCKED.
REQ-022 LOCKED SHALL persist until reset (no loss-of-lock detection).
REQ-023 active SHALL rise on the edge entering LOCKED.

Reset
REQ-024 On reset high, asynchronously: state HUNT, sr, bit_cnt, comma_cnt, ch_ptr, data_out, valid_out, active all 0.
REQ-025 Reset asserted mid-word or mid-lock SHALL discard partial word; after release, reacquisition SHALL require a fresh LOCK_COUNT commas.

Verification (defaults W=8, COMMA=BC, LOCK_COUNT=4, N_CH=4)
REQ-026 Lock and distribute: 4x BC then FF,EE,DD,CC -> active=1 at last bit of 4th BC; valid_out 0001,0010,0100,1000 on successive boundaries; lanes 0..3 = FF,EE,DD,CC.
REQ-027 Bit offset: 3 random bits then 4x BC, 11 -> HUNT aligns on first BC, lock after 4th, 11 in lane 0.
REQ-028 Broken preamble: BC,BC,BC,7C,BC,BC,BC,BC,22 -> no lock after 7C (back to HUNT, re-hunts); lock after final BC; 22 in lane 0; no valid before.
REQ-029 Comma resync and wrap: locked, send A1,A2,A3,A4,A5,BC,A6 -> A1..A4 lanes 0..3, A5 lane 0, BC no strobe, A6 lane 0.
REQ-030 Reset mid-operation: locked, assert reset during bit 3 of a data word -> all outputs 0 immediately, active=0; after release, data without 4 commas produces no valid.
REQ-031 Parametric: W=10, COMMA=10'h17C, N_CH=2, LOCK_COUNT=2 -> lock after 2 commas, words alternate lanes 0/1.
